ram_responder: RTL



---
 rtl/ram_responder_if.sv | 26 ++
 rtl/ram_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_responder_if.sv
`default_nettype none
// ============================================================================
//  ram_responder_if : CPU RAM request port bundle (arbiter <-> responder)
//  Rev 1.0
// ============================================================================
interface ram_responder_if;
  logic [63:0] i_ram_addr;
  logic        i_ram_wen;
  logic        i_ram_valid;
  logic        o_ram_ready;
  logic [63:0] i_ram_wdata;
  logic [2:0]  i_ram_size;
  logic [63:0] o_ram_rdata;
  logic        o_ram_err;

  modport master (
    output i_ram_addr, i_ram_wen, i_ram_valid, i_ram_wdata, i_ram_size,
    input  o_ram_ready, o_ram_rdata, o_ram_err
  );

  modport slave (
    input  i_ram_addr, i_ram_wen, i_ram_valid, i_ram_wdata, i_ram_size,
    output o_ram_ready, o_ram_rdata, o_ram_err
  );
endinterface
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
//  ram_responder : single-outstanding RAM responder, 64-bit word array,
//  programmable latency. Optional macro RAM_RAND_LAT_EN adds LFSR jitter.
//  Rev 1.0
// ============================================================================
module ram_responder #(
  parameter int          MEM_AW    = 16,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  wire              clk,
  input  wire              rst,
  ram_responder_if.slave   bus
);

  localparam logic [63:0] MEM_END = BASE_ADDR + (64'd8 << MEM_AW);
  localparam int          DEPTH   = 1 << MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        ready_q, ready_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  // Decode of the latched request
  logic [2:0]        off;
  logic [3:0]        nbytes;
  logic              req_err;
  logic [MEM_AW-1:0] idx;
  logic [7:0]        byte_mask;
  logic [7:0]        lo_bytes;
  logic [63:0]       bit_mask;
  logic [63:0]       lo_mask;
  logic [63:0]       mem_word;
  logic [63:0]       rd_val;
  logic [63:0]       wr_val;
  logic              mem_we;
  logic [4:0]        cnt_init;

  always_comb begin
    off       = addr_q[2:0];
    nbytes    = 4'd1 << size_q[1:0];
    req_err   = size_q[2]
              || (({1'b0, off} + nbytes) > 4'd8)
              || (addr_q < BASE_ADDR)
              || (addr_q >= MEM_END);
    idx       = MEM_AW'((addr_q - BASE_ADDR) >> 3);
    lo_bytes  = 8'((16'd1 << nbytes) - 16'd1);
    byte_mask = lo_bytes << off;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
      lo_mask[8*i +: 8]  = {8{lo_bytes[i]}};
    end
    mem_word  = mem[idx];
    rd_val    = (mem_word >> {off, 3'b000}) & lo_mask;
    wr_val    = (mem_word & ~bit_mask) | ((wdata_q << {off, 3'b000}) & bit_mask);
  end

`ifdef RAM_RAND_LAT_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_step;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_step) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    cnt_init = 5'(LATENCY - 1) + {3'b000, lfsr_q[1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    cnt_init = 5'(LATENCY - 1);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    ready_d = 1'b0;
    rdata_d = 64'd0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
`ifdef RAM_RAND_LAT_EN
    lfsr_step = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_ram_valid) begin
          addr_d  = bus.i_ram_addr;
          wen_d   = bus.i_ram_wen;
          wdata_d = bus.i_ram_wdata;
          size_d  = bus.i_ram_size;
          cnt_d   = cnt_init;
          state_d = S_BUSY;
`ifdef RAM_RAND_LAT_EN
          lfsr_step = 1'b1;
`endif
        end
      end
      S_BUSY: begin
        if (!bus.i_ram_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = req_err;
          rdata_d = (req_err || wen_q) ? 64'd0 : rd_val;
          mem_we  = wen_q && !req_err;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= 64'd0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      size_q  <= 3'd0;
      ready_q <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx] <= wr_val;
    end
  end

  assign bus.o_ram_ready = ready_q;
  assign bus.o_ram_rdata = rdata_q;
  assign bus.o_ram_err   = err_q;

endmodule
`default_nettype wire
